instr_decode_stage: RTL
=======================

# instr_decode_stage

Registered, handshaked instruction decode stage for the MIPS-style datapath. Accepts one 32-bit instruction word per valid/ready transfer, classifies the 6-bit opcode as R-, I- or J-type (or illegal in strict mode), splits out all instruction fields, and presents them one cycle later behind a registered valid/ready output. It sits between instruction fetch and register read. It also keeps saturating per-class instruction counters for performance monitoring.

## Interface
- CNT_WIDTH, 16, width of each class counter
- STRICT, 0, 0: any opcode other than 0/2/3 is I-type; 1: only the listed I-type opcodes are legal, others flagged illegal
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept a word this cycle
- in_instr  in  32  instruction word
- out_valid  out  1  decoded outputs valid
- out_ready  in  1  downstream accepts decoded outputs
- rtype, itype, jtype, illegal  out  1 each  class flags, one-hot while out_valid
- opcode  out  6  instr[31:26]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm  out  16  instr[15:0]
- imm_sext  out  32  imm sign-extended
- target  out  26  instr[25:0]
- cnt_clear  in  1  synchronous clear of all counters
- cnt_r, cnt_i, cnt_j, cnt_ill  out  CNT_WIDTH each  class counters

## Operation
- Classification: opcode 0 -> rtype; 2 or 3 -> jtype; otherwise itype when STRICT=0.
- STRICT=1: itype only for opcodes 1, 4–15, 32–38, 40–43. All other non-R/J opcodes -> illegal=1, other flags 0.
- Exactly one of rtype/itype/jtype/illegal is 1 while out_valid=1. When STRICT=0, illegal is constant 0.
- All field outputs are taken from the registered word. They are produced for every class, regardless of type.
- Single output register, with in_ready = !out_valid || out_ready (combinational from out_ready).
- Input transfer: in_valid && in_ready. On the next edge the output register loads the decode and out_valid=1.
- Output transfer: out_valid && out_ready. If there is no simultaneous input transfer, out_valid goes to 0 on the next edge.
- Simultaneous input and output transfer in one cycle: the register is reloaded with the new word, and out_valid stays 1. The stage sustains full throughput with no bubble.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Counters: on each output transfer, the counter for the presented class increments by 1.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- cnt_clear=1 zeroes all counters on the next edge. Clear has priority over an increment in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous assert):
  - out_valid=0.
  - All class flags and field outputs are 0.
  - All counters are 0.
  - in_ready=1 while rst_n=0 and after reset.
- Reset asserted mid-stall: the pending decoded word is discarded and is not counted.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Counters update on the edge that completes the output transfer. They are visible the following cycle.

## Test plan
- Reset then single words with out_ready=1:
  - in_instr=0x00221820 -> next cycle: rtype=1, rs=1, rt=2, rd=3, funct=0x20, cnt_r=1.
  - 0x08100000 -> jtype=1, opcode=2, target=0x0100000.
  - 0x0C000004 -> jtype=1, opcode=3.
- I-type fields:
  - 0x2022FFFB (addi) -> itype=1, rs=1, rt=2, imm=0xFFFB, imm_sext=0xFFFFFFFB.
  - 0x10000000 (opcode 4) -> itype=1.
- Mode check:
  - 0xFC000000 with STRICT=0 -> itype=1, illegal=0.
  - 0xFC000000 with STRICT=1 -> illegal=1, itype=0, cnt_ill=1.
  - Opcode 10 (0x28000000) with STRICT=1 -> itype=1.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout.
  - Then raise out_ready for a 4-word back-to-back stream -> out_valid stays 1 for 4 consecutive cycles, words appear in order, and counter sum=4.
- Counter saturation/clear:
  - CNT_WIDTH=2, send 5 R-type words -> cnt_r=3.
  - Assert cnt_clear in the same cycle as an output transfer -> cnt_r=0 the next cycle.
- Asynchronous reset while out_valid=1 and stalled -> out_valid=0 immediately and counters=0.
  - After rst_n returns high, the first new word decodes normally after 1 cycle.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered valid/ready decode of a MIPS-style instruction word into class flags and fields,
// with saturating per-class transfer counters.
module instr_decode_stage #(
    parameter int CNT_WIDTH = 16,
    parameter bit STRICT    = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [31:0]          i_in_instr,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_rtype,
    output logic                 o_itype,
    output logic                 o_jtype,
    output logic                 o_illegal,
    output logic [5:0]           o_opcode,
    output logic [4:0]           o_rs,
    output logic [4:0]           o_rt,
    output logic [4:0]           o_rd,
    output logic [4:0]           o_shamt,
    output logic [5:0]           o_funct,
    output logic [15:0]          o_imm,
    output logic [31:0]          o_imm_sext,
    output logic [25:0]          o_target,
    input  logic                 i_cnt_clear,
    output logic [CNT_WIDTH-1:0] o_cnt_r,
    output logic [CNT_WIDTH-1:0] o_cnt_i,
    output logic [CNT_WIDTH-1:0] o_cnt_j,
    output logic [CNT_WIDTH-1:0] o_cnt_ill
);
    logic                 r_valid;
    logic [31:0]          r_instr;
    logic [3:0]           r_cls;
    logic [CNT_WIDTH-1:0] r_cnt [4];
    logic [5:0]           w_op;
    logic                 w_r, w_j, w_i, w_ill, w_i_legal;
    logic                 w_in_xfer, w_out_xfer;
    assign o_in_ready = !r_valid || i_out_ready;
    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = r_valid && i_out_ready;
    always_comb begin
        w_op      = i_in_instr[31:26];
        w_r       = w_op == 6'd0;
        w_j       = w_op == 6'd2 || w_op == 6'd3;
        w_i_legal = w_op == 6'd1 || (w_op >= 6'd4 && w_op <= 6'd15) ||
                    (w_op >= 6'd32 && w_op <= 6'd38) || (w_op >= 6'd40 && w_op <= 6'd43);
        w_i       = !w_r && !w_j && (!STRICT || w_i_legal);
        w_ill     = !w_r && !w_j && !w_i;
    end
    // class vector order: {illegal, jtype, itype, rtype}, matching r_cnt indices
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_cls   <= '0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_instr <= i_in_instr;
            r_cls   <= {w_ill, w_j, w_i, w_r};
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end
    for (genvar k = 0; k < 4; k++) begin : g_cnt
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_cnt[k] <= '0;
            else if (i_cnt_clear)
                r_cnt[k] <= '0;
            else if (w_out_xfer && r_cls[k] && r_cnt[k] != '1)
                r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
        end
    end
    assign o_out_valid = r_valid;
    assign o_rtype     = r_cls[0];
    assign o_itype     = r_cls[1];
    assign o_jtype     = r_cls[2];
    assign o_illegal   = r_cls[3];
    assign o_opcode    = r_instr[31:26];
    assign o_rs        = r_instr[25:21];
    assign o_rt        = r_instr[20:16];
    assign o_rd        = r_instr[15:11];
    assign o_shamt     = r_instr[10:6];
    assign o_funct     = r_instr[5:0];
    assign o_imm       = r_instr[15:0];
    assign o_imm_sext  = {{16{r_instr[15]}}, r_instr[15:0]};
    assign o_target    = r_instr[25:0];
    assign o_cnt_r     = r_cnt[0];
    assign o_cnt_i     = r_cnt[1];
    assign o_cnt_j     = r_cnt[2];
    assign o_cnt_ill   = r_cnt[3];
endmodule
